ram_io_responder: RTL
=====================

Name: ram_io_responder

Overview:
- Responder end of the byte-serial RAM bus that the memory controller drives through mem_ram_addr, mem_ram_data and mem_ram_wr, and samples through ram_data.
- Provides byte-wide storage with 1-cycle read latency.
- Decodes an I/O window for console TX/RX and program-end signalling.
- Produces the global rdy; lowering rdy freezes the CPU while the TX FIFO is full.

Parameters:
- ADDR_WIDTH, 17, RAM index width; depth 2^ADDR_WIDTH bytes.
- TX_DEPTH_LOG, 3, log2 of TX FIFO depth (8 entries).
- IO_SEL, 2'b11, value of addr[17:16] that selects the I/O window.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- mem_ram_addr  in  32  byte address from the memory controller.
- mem_ram_data  in  8  write byte from the memory controller.
- mem_ram_wr  in  1  1 = write, 0 = read.
- ram_data  out  8  registered read byte; valid the cycle after the address is presented.
- ram_rdy  out  1  global rdy to the CPU; 0 freezes the CPU.
- io_tx_data  out  8  console TX byte (FIFO head).
- io_tx_valid  out  1  TX FIFO not empty.
- io_tx_ready  in  1  console accepts io_tx_data when io_tx_valid && io_tx_ready.
- io_rx_data  in  8  console RX byte.
- io_rx_valid  in  1  RX byte available.
- io_rx_ack  out  1  1-cycle pulse: RX byte consumed.
- prog_end  out  1  sticky; program finished.
- prog_end_code  out  8  exit byte.

Behaviour:
- Reset (rst=0, asynchronous): ram_data=0, io_rx_ack=0, prog_end=0, prog_end_code=0.
- Reset also empties the FIFO: read/write pointers and count=0, so io_tx_valid=0 and ram_rdy=1.
- RAM contents are not reset. Reset mid-transfer discards queued TX bytes.
- Sampling rule: the bus is sampled only on edges where ram_rdy=1. With ram_rdy=0 the bus is ignored and ram_data holds. This guarantees each held bus value is consumed exactly once.
- Decode: I/O when addr[17:16]==IO_SEL; otherwise RAM, indexed by addr[ADDR_WIDTH-1:0]. Upper bits [31:18] are ignored.
- RAM write: mem[idx]<=mem_ram_data. ram_data is unchanged.
- RAM read: ram_data<=mem[idx], visible the next cycle.
- I/O write 0x30000: push mem_ram_data to the TX FIFO.
- I/O write 0x30004: prog_end<=1, prog_end_code<=mem_ram_data.
- I/O write, any other I/O address: ignored.
- I/O read 0x30000: ram_data<=io_rx_valid ? io_rx_data : 0. io_rx_ack<=io_rx_valid, for one cycle.
- I/O read 0x30004: ram_data<={6'b0, io_rx_valid, tx_full}.
- I/O read, any other I/O address: ram_data<=0.
- TX FIFO is circular; pointers wrap modulo 2^TX_DEPTH_LOG.
  - Pop when io_tx_valid && io_tx_ready.
  - Push and pop in the same cycle: count unchanged.
  - io_tx_data = entry at the read pointer (combinational from registered state).
- ram_rdy = !tx_full (combinational from the registered count).
  - A push that fills the FIFO drops ram_rdy on the next cycle; the CPU is frozen with its next request held on the bus.
  - The first pop raises ram_rdy; the held request is then sampled once.
  - Pop while full with rdy low is legal; no push occurs that cycle.
- Push is never attempted while full, by construction of the sampling rule.
- Repeated writes to 0x30004: the latest value overwrites prog_end_code; prog_end stays 1.

Optional Feature:
- PROG_END_HALT_EN defined:
  - Once prog_end=1, ram_rdy is forced to 0 permanently, until reset.
  - The TX FIFO keeps draining so queued console output is flushed.
  - Bus requests are never sampled again.
- PROG_END_HALT_EN undefined: prog_end is a flag only; ram_rdy depends on tx_full alone.

Test Plan:
- Write 0xA5 to addr 0x00010, then read 0x00010 -> ram_data=0xA5 exactly one cycle after the read address is presented; value holds until the next sampled read.
- Push 8 bytes 0x41..0x48 to 0x30000 with io_tx_ready=0 -> ram_rdy=0 after the 8th push; raise io_tx_ready -> bytes emitted in order 0x41..0x48, no duplicates; ram_rdy=1 after the first pop.
- With FIFO full, hold a RAM write of 0x77 to 0x00020 on the bus, then pop one byte -> exactly one write occurs; a subsequent read of 0x00020 returns 0x77.
- io_rx_valid=1, io_rx_data=0x5A, read 0x30000 -> ram_data=0x5A, io_rx_ack pulses 1 cycle; with io_rx_valid=0 -> ram_data=0x00, no ack.
- Write 0x03 to 0x30004 -> prog_end=1, prog_end_code=0x03. With PROG_END_HALT_EN, ram_rdy stays 0 while 3 queued TX bytes still drain.
- Assert rst=0 asynchronously mid-burst with 5 bytes queued -> outputs clear immediately without a clock edge; io_tx_valid=0, ram_rdy=1; RAM byte previously written at 0x00010 still reads 0xA5.

Source files
------------

// File: rtl/ram_io_responder_if.sv
// Byte-serial RAM bus between the memory controller (master) and the
// RAM/IO responder (slave), including the global ready back to the CPU.
interface ram_io_responder_if;
   logic [31:0] mem_ram_addr;
   logic [7:0]  mem_ram_data;
   logic        mem_ram_wr;
   logic [7:0]  ram_data;
   logic        ram_rdy;

   modport master (
      output mem_ram_addr, mem_ram_data, mem_ram_wr,
      input  ram_data, ram_rdy
   );

   modport slave (
      input  mem_ram_addr, mem_ram_data, mem_ram_wr,
      output ram_data, ram_rdy
   );
endinterface

// File: rtl/ram_io_responder.sv
// Byte RAM plus console/program-end I/O window behind the RAM bus; drives global rdy.
// Optional: define PROG_END_HALT_EN to hold rdy low permanently once prog_end is set.
module ram_io_responder #(
   parameter int         ADDR_WIDTH   = 17,
   parameter int         TX_DEPTH_LOG = 3,
   parameter logic [1:0] IO_SEL       = 2'b11
) (
   input  logic                clk,
   input  logic                rst,
   ram_io_responder_if.slave   bus,
   output logic [7:0]          io_tx_data,
   output logic                io_tx_valid,
   input  logic                io_tx_ready,
   input  logic [7:0]          io_rx_data,
   input  logic                io_rx_valid,
   output logic                io_rx_ack,
   output logic                prog_end,
   output logic [7:0]          prog_end_code
);

   localparam int TX_DEPTH = 1 << TX_DEPTH_LOG;
   localparam logic [TX_DEPTH_LOG:0]   C_CNT_FULL = (TX_DEPTH_LOG + 1)'(TX_DEPTH);
   localparam logic [TX_DEPTH_LOG:0]   C_CNT_ONE  = (TX_DEPTH_LOG + 1)'(1);
   localparam logic [TX_DEPTH_LOG:0]   C_CNT_ZERO = (TX_DEPTH_LOG + 1)'(0);
   localparam logic [TX_DEPTH_LOG-1:0] C_PTR_ONE  = TX_DEPTH_LOG'(1);
   localparam logic [15:0]             C_OFF_DATA = 16'h0000;
   localparam logic [15:0]             C_OFF_CTRL = 16'h0004;

   logic [7:0]              r_mem [0:(2**ADDR_WIDTH)-1];
   logic [7:0]              r_tx_mem [0:TX_DEPTH-1];
   logic [TX_DEPTH_LOG-1:0] r_wr_ptr;
   logic [TX_DEPTH_LOG-1:0] r_rd_ptr;
   logic [TX_DEPTH_LOG:0]   r_count;
   logic [7:0]              r_ram_data;
   logic                    r_rx_ack;
   logic                    r_prog_end;
   logic [7:0]              r_prog_end_code;

   logic                    w_full;
   logic                    w_rdy;
   logic                    w_pop;
   logic                    w_is_io;
   logic [15:0]             w_io_off;
   logic [ADDR_WIDTH-1:0]   w_idx;
   logic                    w_ram_wr;
   logic                    w_ram_rd;
   logic                    w_io_rd;
   logic [7:0]              w_io_rd_data;
   logic                    w_tx_push;
   logic                    w_end_wr;
   logic                    w_rx_ack_set;
   logic                    w_unused;

   assign w_full      = (r_count == C_CNT_FULL);
   assign io_tx_valid = (r_count != C_CNT_ZERO);
   assign io_tx_data  = r_tx_mem[r_rd_ptr];
   assign w_pop       = io_tx_valid && io_tx_ready;

`ifdef PROG_END_HALT_EN
   // After program end the CPU stays frozen; only the TX drain keeps running.
   assign w_rdy = !w_full && !r_prog_end;
`else
   assign w_rdy = !w_full;
`endif

   assign w_is_io  = (bus.mem_ram_addr[17:16] == IO_SEL);
   assign w_io_off = bus.mem_ram_addr[15:0];
   assign w_idx    = bus.mem_ram_addr[ADDR_WIDTH-1:0];
   assign w_unused = ^bus.mem_ram_addr[31:18];

   assign bus.ram_data  = r_ram_data;
   assign bus.ram_rdy   = w_rdy;
   assign io_rx_ack     = r_rx_ack;
   assign prog_end      = r_prog_end;
   assign prog_end_code = r_prog_end_code;

   // Decode the bus; nothing is acted on unless rdy is high at this edge.
   always_comb begin
      w_ram_wr     = 1'b0;
      w_ram_rd     = 1'b0;
      w_io_rd      = 1'b0;
      w_io_rd_data = 8'h00;
      w_tx_push    = 1'b0;
      w_end_wr     = 1'b0;
      w_rx_ack_set = 1'b0;
      if (w_rdy) begin
         if (w_is_io) begin
            if (bus.mem_ram_wr) begin
               case (w_io_off)
                  C_OFF_DATA: w_tx_push = 1'b1;
                  C_OFF_CTRL: w_end_wr  = 1'b1;
                  default:    w_tx_push = 1'b0;
               endcase
            end else begin
               w_io_rd = 1'b1;
               case (w_io_off)
                  C_OFF_DATA: begin
                     w_io_rd_data = io_rx_valid ? io_rx_data : 8'h00;
                     w_rx_ack_set = io_rx_valid;
                  end
                  C_OFF_CTRL: w_io_rd_data = {6'b000000, io_rx_valid, w_full};
                  default:    w_io_rd_data = 8'h00;
               endcase
            end
         end else begin
            if (bus.mem_ram_wr) begin
               w_ram_wr = 1'b1;
            end else begin
               w_ram_rd = 1'b1;
            end
         end
      end else begin
         w_ram_wr = 1'b0;
      end
   end

   // RAM array write port (contents survive reset).
   always_ff @(posedge clk) begin
      if (w_ram_wr) begin
         r_mem[w_idx] <= bus.mem_ram_data;
      end
   end

   // TX FIFO storage (contents are don't-care while count says empty).
   always_ff @(posedge clk) begin
      if (w_tx_push) begin
         r_tx_mem[r_wr_ptr] <= bus.mem_ram_data;
      end
   end

   // TX FIFO pointers and occupancy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= {TX_DEPTH_LOG{1'b0}};
         r_rd_ptr <= {TX_DEPTH_LOG{1'b0}};
         r_count  <= C_CNT_ZERO;
      end else begin
         if (w_tx_push) begin
            r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
         end
         case ({w_tx_push, w_pop})
            2'b10:   r_count <= r_count + C_CNT_ONE;
            2'b01:   r_count <= r_count - C_CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // Read data, RX acknowledge pulse and program-end flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ram_data      <= 8'h00;
         r_rx_ack        <= 1'b0;
         r_prog_end      <= 1'b0;
         r_prog_end_code <= 8'h00;
      end else begin
         if (w_ram_rd) begin
            r_ram_data <= r_mem[w_idx];
         end else if (w_io_rd) begin
            r_ram_data <= w_io_rd_data;
         end
         r_rx_ack <= w_rx_ack_set;
         if (w_end_wr) begin
            r_prog_end      <= 1'b1;
            r_prog_end_code <= bus.mem_ram_data;
         end
      end
   end

endmodule
